// File: rtl/reg_access_pkg.sv
// reg_access_pkg: op encodings, controller states and default width for the 256-bit register port.
package reg_access_pkg;
    localparam int DEF_WIDTH = 256;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLEAR = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;
endpackage

// File: rtl/rmw_merge.sv
// rmw_merge: combinational new-word computation for WRITE, SET and CLEAR.
module rmw_merge
    import reg_access_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] old,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] merged
);
    always_comb merged = op == OP_SET   ? old | mask :
                         op == OP_CLEAR ? old & ~mask :
                         op == OP_WRITE ? mask : old;
endmodule

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences the register Enable/ReadWrite protocol for read, write, set and clear requests.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [1:0]       ReqOp,
    input  logic [WIDTH-1:0] ReqData,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RegEnable,
    output logic             RegReadWrite,
    output logic [WIDTH-1:0] RegWrData,
    input  logic [WIDTH-1:0] RegRdData
);
    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] merged;

    // merge straight from the read bus so the write word is registered by the end of RD
    rmw_merge #(.WIDTH(WIDTH)) u_merge (
        .op    (op_q),
        .old   (RegRdData),
        .mask  (data_q),
        .merged(merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_READ;
            data_q       <= '0;
            hold         <= '0;
            ReqReady     <= 1'b1;
            RspValid     <= 1'b0;
            RspData      <= '0;
            RegEnable    <= 1'b0;
            RegReadWrite <= 1'b1;
            RegWrData    <= '0;
        end else begin
            case (state)
                IDLE: if (ReqValid) begin
                    op_q      <= op_e'(ReqOp);
                    data_q    <= ReqData;
                    ReqReady  <= 1'b0;
                    RegEnable <= 1'b1;
                    if (op_e'(ReqOp) == OP_WRITE) begin
                        state        <= WR;
                        RegReadWrite <= 1'b0;
                        RegWrData    <= ReqData;
                    end else begin
                        state        <= RD;
                        RegReadWrite <= 1'b1;
                    end
                end
                RD: begin
                    hold <= RegRdData;
                    if (op_q == OP_READ) begin
                        state     <= RSP;
                        RegEnable <= 1'b0;
                        RspValid  <= 1'b1;
                        RspData   <= RegRdData;
                    end else begin
                        state        <= WR;
                        RegReadWrite <= 1'b0;
                        RegWrData    <= merged;
                    end
                end
                WR: begin
                    state        <= RSP;
                    RegEnable    <= 1'b0;
                    RegReadWrite <= 1'b1;
                    RspValid     <= 1'b1;
                    RspData      <= op_q == OP_WRITE ? data_q : hold;
                end
                RSP: if (RspReady) begin
                    state    <= IDLE;
                    RspValid <= 1'b0;
                    ReqReady <= 1'b1;
                end
            endcase
        end
    end
endmodule
